// File: rtl/edf_irq_delivery_if.sv
// Winner/claim and core request/ack/eoi signal bundle for the EDF delivery stage.
// slave = delivery stage, master = controller + core side.
interface edf_irq_delivery_if #(
  parameter int NrIrqs   = 4,
  parameter int TsWidth  = 24,
  parameter int CntWidth = 16
);
  localparam int IdWidth = $clog2(NrIrqs);

  logic                ic_valid_i;
  logic [IdWidth-1:0]  ic_id_i;
  logic [TsWidth-1:0]  ic_dl_i;
  logic                ic_ack_o;
  logic [IdWidth-1:0]  ic_ack_id_o;
  logic                core_irq_o;
  logic [IdWidth-1:0]  core_irq_id_o;
  logic                core_ack_i;
  logic                core_eoi_i;
  logic                active_o;
  logic                miss_o;
  logic [IdWidth-1:0]  miss_id_o;
  logic [CntWidth-1:0] miss_cnt_o;

  modport slave (
    input  ic_valid_i, ic_id_i, ic_dl_i, core_ack_i, core_eoi_i,
    output ic_ack_o, ic_ack_id_o, core_irq_o, core_irq_id_o,
           active_o, miss_o, miss_id_o, miss_cnt_o
  );

  modport master (
    output ic_valid_i, ic_id_i, ic_dl_i, core_ack_i, core_eoi_i,
    input  ic_ack_o, ic_ack_id_o, core_irq_o, core_irq_id_o,
           active_o, miss_o, miss_id_o, miss_cnt_o
  );
endinterface

// File: rtl/edf_irq_delivery.sv
// Presents the EDF winner to the core (req/ack/eoi), claims it back to the controller, flags deadline misses.
// core_irq_o 1 cycle after a sampled winner; ic_ack_o/miss_o are registered 1-cycle pulses; one interrupt in flight.
module edf_irq_delivery #(
  parameter int NrIrqs   = 4,
  parameter int TsWidth  = 24,
  parameter int CntWidth = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [63:0]        mtime_i,
  edf_irq_delivery_if.slave  bus
);
  localparam int IdWidth = $clog2(NrIrqs);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [IdWidth-1:0]   r_id, w_id_nxt;
  logic [TsWidth-1:0]   r_dl, w_dl_nxt;
  logic                 w_take, w_retarget, w_to_idle;
  logic                 r_ack;
  logic [IdWidth-1:0]   r_ack_id;
  logic                 r_miss_flag, r_miss;
  logic [IdWidth-1:0]   r_miss_id;
  logic [CntWidth-1:0]  r_miss_cnt;
  logic [TsWidth-1:0]   w_diff;
  logic                 w_late, w_miss_hit;
  logic                 w_unused_mtime;

  assign w_unused_mtime = ^mtime_i[63:TsWidth];

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_dl_nxt    = r_dl;
    w_take      = 1'b0;
    w_retarget  = 1'b0;
    w_to_idle   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ic_valid_i) begin
          w_state_nxt = S_REQ;
          w_id_nxt    = bus.ic_id_i;
          w_dl_nxt    = bus.ic_dl_i;
        end
      end
      S_REQ: begin
        // ack beats withdraw beats retarget; a simultaneous eoi is simply not looked at here
        if (bus.core_ack_i) begin
          w_state_nxt = S_ACTIVE;
          w_take      = 1'b1;
        end else if (!bus.ic_valid_i) begin
          w_state_nxt = S_IDLE;
          w_to_idle   = 1'b1;
        end else if (bus.ic_id_i != r_id) begin
          w_id_nxt    = bus.ic_id_i;
          w_dl_nxt    = bus.ic_dl_i;
          w_retarget  = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (bus.core_eoi_i) begin
          w_state_nxt = S_IDLE;
          w_to_idle   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Signed modular difference keeps the comparison correct across timer wrap.
  assign w_diff     = mtime_i[TsWidth-1:0] - r_dl;
  assign w_late     = ((r_state == S_REQ) || (r_state == S_ACTIVE)) &&
                      !w_diff[TsWidth-1] && (w_diff != '0);
  assign w_miss_hit = w_late && !r_miss_flag && !w_retarget;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_dl        <= '0;
      r_ack       <= 1'b0;
      r_ack_id    <= '0;
      r_miss_flag <= 1'b0;
      r_miss      <= 1'b0;
      r_miss_id   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_id     <= w_id_nxt;
      r_dl     <= w_dl_nxt;
      r_ack    <= w_take;
      if (w_take) begin
        r_ack_id <= r_id;
      end
      r_miss <= w_miss_hit;
      if (w_to_idle || w_retarget) begin
        r_miss_flag <= 1'b0;
      end else if (w_miss_hit) begin
        r_miss_flag <= 1'b1;
      end
      if (w_miss_hit) begin
        r_miss_id <= r_id;
        if (r_miss_cnt != {CntWidth{1'b1}}) begin
          r_miss_cnt <= r_miss_cnt + {{(CntWidth-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign bus.core_irq_o    = (r_state == S_REQ);
  assign bus.core_irq_id_o = r_id;
  assign bus.active_o      = (r_state == S_ACTIVE);
  assign bus.ic_ack_o      = r_ack;
  assign bus.ic_ack_id_o   = r_ack_id;
  assign bus.miss_o        = r_miss;
  assign bus.miss_id_o     = r_miss_id;
  assign bus.miss_cnt_o    = r_miss_cnt;
endmodule

// File: tb/tb_edf_irq_delivery.sv
// Directed bench for edf_irq_delivery: claim acks and miss pulses go through a scoreboard,
// request/active levels are checked inline against hand-computed cycle timing.
module tb_edf_irq_delivery;
  logic        clk;
  logic        rst_n;
  logic [63:0] mtime;
  int          checks   = 0;
  int          failures = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] cnt;
  } miss_t;

  logic [1:0] ack_q[$];
  miss_t      miss_q[$];

  edf_irq_delivery_if #(.NrIrqs(4), .TsWidth(24), .CntWidth(2)) bus ();

  edf_irq_delivery #(.NrIrqs(4), .TsWidth(24), .CntWidth(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .mtime_i (mtime),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack/miss pulse must match the oldest expectation.
  initial begin
    logic [1:0] e_ack;
    miss_t      e_miss;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ic_ack_o) begin
          if (ack_q.size() == 0) chk("unexpected_ack_q_size", ack_q.size(), 1);
          else begin
            e_ack = ack_q.pop_front();
            chk("ack_id", {30'd0, bus.ic_ack_id_o}, {30'd0, e_ack});
          end
        end
        if (bus.miss_o) begin
          if (miss_q.size() == 0) chk("unexpected_miss_q_size", miss_q.size(), 1);
          else begin
            e_miss = miss_q.pop_front();
            chk("miss_id", {30'd0, bus.miss_id_o}, {30'd0, e_miss.id});
            chk("miss_cnt", {30'd0, bus.miss_cnt_o}, {30'd0, e_miss.cnt});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mtime = 64'd100;
    bus.ic_valid_i = 1'b0;
    bus.ic_id_i    = '0;
    bus.ic_dl_i    = '0;
    bus.core_ack_i = 1'b0;
    bus.core_eoi_i = 1'b0;
    #3;
    chk("rst_outputs", {bus.core_irq_o, bus.active_o, bus.ic_ack_o, bus.miss_o,
                        bus.core_irq_id_o, bus.miss_cnt_o}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();

    // Basic service: valid at cycle 0, ack at 3, eoi at 6.
    bus.ic_valid_i = 1'b1; bus.ic_id_i = 2'd2; bus.ic_dl_i = 24'd1000;
    step();
    chk("basic_irq_c1", {bus.core_irq_o, bus.core_irq_id_o}, {29'd0, 1'b1, 2'd2});
    step();
    chk("basic_irq_c2", {31'd0, bus.core_irq_o}, 32'd1);
    step();
    chk("basic_irq_c3", {31'd0, bus.core_irq_o}, 32'd1);
    bus.core_ack_i = 1'b1; ack_q.push_back(2'd2);
    step();
    bus.core_ack_i = 1'b0; bus.ic_valid_i = 1'b0;
    chk("basic_c4", {bus.core_irq_o, bus.active_o}, 32'b01);
    step();
    chk("basic_active_c5", {31'd0, bus.active_o}, 32'd1);
    step();
    chk("basic_active_c6", {31'd0, bus.active_o}, 32'd1);
    bus.core_eoi_i = 1'b1;
    step();
    bus.core_eoi_i = 1'b0;
    chk("basic_idle_c7", {bus.core_irq_o, bus.active_o}, 32'b00);

    // Retarget id 1 -> 3 before the ack.
    bus.ic_valid_i = 1'b1; bus.ic_id_i = 2'd1; bus.ic_dl_i = 24'd400;
    step();
    chk("retgt_id1", {bus.core_irq_o, bus.core_irq_id_o}, {29'd0, 1'b1, 2'd1});
    bus.ic_id_i = 2'd3; bus.ic_dl_i = 24'd500;
    step();
    chk("retgt_id3", {bus.core_irq_o, bus.core_irq_id_o}, {29'd0, 1'b1, 2'd3});
    bus.core_ack_i = 1'b1; bus.core_eoi_i = 1'b1; ack_q.push_back(2'd3);
    step();
    bus.core_ack_i = 1'b0; bus.core_eoi_i = 1'b0; bus.ic_valid_i = 1'b0;
    chk("retgt_active_eoi_dropped", {bus.core_irq_o, bus.active_o}, 32'b01);
    bus.core_eoi_i = 1'b1;
    step();
    bus.core_eoi_i = 1'b0;
    chk("retgt_idle", {31'd0, bus.active_o}, 32'd0);

    // Withdraw: valid drops in REQ, later ack ignored.
    bus.ic_valid_i = 1'b1; bus.ic_id_i = 2'd0; bus.ic_dl_i = 24'd900;
    step();
    chk("wd_irq", {31'd0, bus.core_irq_o}, 32'd1);
    bus.ic_valid_i = 1'b0;
    step();
    chk("wd_dropped", {31'd0, bus.core_irq_o}, 32'd0);
    bus.core_ack_i = 1'b1;
    step();
    bus.core_ack_i = 1'b0;
    chk("wd_ack_ignored", {bus.core_irq_o, bus.active_o}, 32'b00);
    step();

    // Deadline miss across timer wrap.
    mtime = 64'h1_00FF_FFF0;
    bus.ic_valid_i = 1'b1; bus.ic_id_i = 2'd1; bus.ic_dl_i = 24'h000010;
    step();
    bus.core_ack_i = 1'b1; ack_q.push_back(2'd1);
    step();
    bus.core_ack_i = 1'b0; bus.ic_valid_i = 1'b0;
    mtime = 64'h1_0100_0010;
    step();
    step();
    chk("wrap_no_miss_at_eq", {30'd0, bus.miss_cnt_o}, 32'd0);
    miss_q.push_back('{id: 2'd1, cnt: 2'd1});
    mtime = 64'h1_0100_0011;
    step();
    chk("wrap_miss_pulse", {bus.miss_o, bus.miss_cnt_o}, {29'd0, 1'b1, 2'd1});
    for (int i = 0; i < 3; i++) begin
      mtime = mtime + 64'd1;
      step();
    end
    bus.core_eoi_i = 1'b1;
    step();
    bus.core_eoi_i = 1'b0;
    step();
    chk("wrap_cnt_after", {30'd0, bus.miss_cnt_o}, 32'd1);

    // Saturation: four late interrupts on a 2-bit counter.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    mtime = 64'h200;
    for (int k = 0; k < 4; k++) begin
      bus.ic_valid_i = 1'b1; bus.ic_id_i = k[1:0]; bus.ic_dl_i = 24'h100;
      step();
      miss_q.push_back('{id: k[1:0], cnt: (k == 3) ? 2'd3 : 2'(k + 1)});
      bus.core_ack_i = 1'b1; ack_q.push_back(k[1:0]);
      step();
      bus.core_ack_i = 1'b0; bus.ic_valid_i = 1'b0; bus.core_eoi_i = 1'b1;
      step();
      bus.core_eoi_i = 1'b0;
      step();
    end
    chk("sat_cnt", {30'd0, bus.miss_cnt_o}, 32'd3);

    // Async reset while ACTIVE; controller keeps the line pended.
    mtime = 64'd100;
    bus.ic_valid_i = 1'b1; bus.ic_id_i = 2'd2; bus.ic_dl_i = 24'd1000;
    step();
    bus.core_ack_i = 1'b1; ack_q.push_back(2'd2);
    step();
    bus.core_ack_i = 1'b0;
    step();
    chk("rst_pre_active", {31'd0, bus.active_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_clear", {bus.core_irq_o, bus.active_o, bus.ic_ack_o, bus.miss_o}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("rst_rereq", {bus.core_irq_o, bus.core_irq_id_o}, {29'd0, 1'b1, 2'd2});
    bus.ic_valid_i = 1'b0;
    step();
    chk("rst_withdrawn", {31'd0, bus.core_irq_o}, 32'd0);
    step();
    step();

    chk("ack_q_drained", ack_q.size(), 0);
    chk("miss_q_drained", miss_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
